// File: rtl/axil_seg_mem.sv
// axil_seg_mem: AXI4-Lite register memory with independent read/write FSMs,
// a seven-segment view of the last OKAY read, and a completed-read counter.
`default_nettype none

module axil_seg_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int SEG_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  output logic [7:0]        disp,
  output logic [7:0]        rd_count
);

  localparam int            IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]    C_OKAY  = 2'b00;
  localparam logic [1:0]    C_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  rstate_t           rstate_q, rstate_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [7:0]        disp_q, disp_d;
  logic [7:0]        rd_count_q, rd_count_d;

  wstate_t           wstate_q, wstate_d;
  logic              aw_got_q, aw_got_d;
  logic              w_got_q, w_got_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              mem_we;

  logic              ar_in_range;
  logic              aw_in_range;
  logic [7:0]        disp_val;

  assign ar_in_range = ({1'b0, araddr} < C_DEPTH);
  assign aw_in_range = ({1'b0, awaddr_q} < C_DEPTH);

  // Display image of the currently held read data
  always_comb begin
    disp_val = 8'hFF;
    if (SEG_EN != 0) begin
      case (rdata_q[3:0])
        4'h0: disp_val = 8'h03;
        4'h1: disp_val = 8'h9F;
        4'h2: disp_val = 8'h25;
        4'h3: disp_val = 8'h0D;
        4'h4: disp_val = 8'h99;
        4'h5: disp_val = 8'h49;
        4'h6: disp_val = 8'h41;
        4'h7: disp_val = 8'h1F;
        4'h8: disp_val = 8'h01;
        4'h9: disp_val = 8'h09;
        4'hA: disp_val = 8'h11;
        4'hB: disp_val = 8'hC1;
        4'hC: disp_val = 8'h63;
        4'hD: disp_val = 8'h85;
        4'hE: disp_val = 8'h61;
        default: disp_val = 8'h71;
      endcase
    end else begin
      disp_val = 8'(rdata_q);
    end
  end

  always_comb begin
    rstate_d   = rstate_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    disp_d     = disp_q;
    rd_count_d = rd_count_q;
    case (rstate_q)
      R_IDLE: begin
        if (arvalid) begin
          rdata_d  = ar_in_range ? mem_q[araddr[IDX_W-1:0]] : '0;
          rresp_d  = ar_in_range ? C_OKAY : C_SLVERR;
          rstate_d = R_DATA;
        end
      end
      default: begin
        if (rready) begin
          rstate_d   = R_IDLE;
          rd_count_d = rd_count_q + 8'd1;
          if (rresp_q == C_OKAY) disp_d = disp_val;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate_q   <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= C_OKAY;
      disp_q     <= 8'hFF;
      rd_count_q <= 8'd0;
    end else begin
      rstate_q   <= rstate_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      disp_q     <= disp_d;
      rd_count_q <= rd_count_d;
    end
  end

  // AW and W are captured independently; execution starts once both are held
  always_comb begin
    wstate_d = wstate_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    bresp_d  = bresp_q;
    mem_we   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (awvalid && !aw_got_q) begin
          aw_got_d = 1'b1;
          awaddr_d = awaddr;
        end
        if (wvalid && !w_got_q) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
        end
        if (aw_got_d && w_got_d) wstate_d = W_EXEC;
      end
      W_EXEC: begin
        mem_we   = aw_in_range;
        bresp_d  = aw_in_range ? C_OKAY : C_SLVERR;
        aw_got_d = 1'b0;
        w_got_d  = 1'b0;
        wstate_d = W_RESP;
      end
      default: begin
        if (bready) wstate_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q <= W_IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      bresp_q  <= C_OKAY;
    end else begin
      wstate_q <= wstate_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      bresp_q  <= bresp_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(i);
    end else if (mem_we) begin
      mem_q[awaddr_q[IDX_W-1:0]] <= wdata_q;
    end
  end

  assign arready  = (rstate_q == R_IDLE);
  assign rvalid   = (rstate_q == R_DATA);
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign awready  = (wstate_q == W_IDLE) && !aw_got_q;
  assign wready   = (wstate_q == W_IDLE) && !w_got_q;
  assign bvalid   = (wstate_q == W_RESP);
  assign bresp    = bresp_q;
  assign disp     = disp_q;
  assign rd_count = rd_count_q;

endmodule

`default_nettype wire
